// File: rtl/mem_write_checker_if.sv
// Bus bundle for mem_write_checker.
//   Table load : exp_we, exp_idx, exp_adr, exp_data
//   Control    : exp_cnt, start
//   Monitored  : memwrite, dataadr, writedata (core data-memory write port)
//   Status     : busy, done, pass, fail, timeout, err_idx, got_adr, got_data, write_cnt
// master = environment driving the checker, slave = the checker itself.
interface mem_write_checker_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 3,
    parameter int CNTW  = 16
);
    logic              exp_we;
    logic [IDXW-1:0]   exp_idx;
    logic [WIDTH-1:0]  exp_adr;
    logic [WIDTH-1:0]  exp_data;
    logic [IDXW:0]     exp_cnt;
    logic              start;
    logic              memwrite;
    logic [WIDTH-1:0]  dataadr;
    logic [WIDTH-1:0]  writedata;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [IDXW-1:0]   err_idx;
    logic [WIDTH-1:0]  got_adr;
    logic [WIDTH-1:0]  got_data;
    logic [CNTW-1:0]   write_cnt;

    modport master (
        output exp_we, exp_idx, exp_adr, exp_data, exp_cnt, start,
        output memwrite, dataadr, writedata,
        input  busy, done, pass, fail, timeout, err_idx, got_adr, got_data, write_cnt
    );

    modport slave (
        input  exp_we, exp_idx, exp_adr, exp_data, exp_cnt, start,
        input  memwrite, dataadr, writedata,
        output busy, done, pass, fail, timeout, err_idx, got_adr, got_data, write_cnt
    );
endinterface

// File: rtl/mem_write_checker.sv
// mem_write_checker: monitors the core's data-memory write port and compares
// each store, in program order, against a table of up to 2**IDXW expected
// (address, data) pairs. A watchdog bounds the run; the verdict is sticky.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_write_checker_if.slave (table load, start, monitored
//                store port, registered status/verdict outputs)
module mem_write_checker #(
    parameter int WIDTH       = 32,
    parameter int IDXW        = 3,
    parameter int TIMEOUT_CYC = 500,
    parameter int CHECK_ADDR  = 1,
    parameter int CNTW        = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_write_checker_if.slave bus
);

    localparam int DEPTH = 1 << IDXW;
    // Counter is wide enough to hold TIMEOUT_CYC itself after the final edge.
    localparam int CYW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDXW:0]  DEPTH_N = (IDXW+1)'(DEPTH);
    localparam logic [IDXW:0]  ONE_N   = (IDXW+1)'(1);
    localparam logic [CYW-1:0] TO_LAST = CYW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

    state_t state, state_nx;

    // Expected-store table; deliberately not reset so it survives a reset.
    logic [DEPTH-1:0][WIDTH-1:0] tbl_adr;
    logic [DEPTH-1:0][WIDTH-1:0] tbl_data;

    logic [IDXW-1:0]  ptr;
    logic [IDXW:0]    n;
    logic [CYW-1:0]   cyc;

    logic             busy_q, done_q, pass_q, fail_q, tmo_q;
    logic [IDXW-1:0]  err_idx_q;
    logic [WIDTH-1:0] got_adr_q, got_data_q;
    logic [CNTW-1:0]  write_cnt_q;

    logic [IDXW:0]    n_in;
    logic [IDXW:0]    n_m1;
    logic             adr_eq, data_eq, hit, last;
    logic             ld, cap, adv;

    assign n_in    = (bus.exp_cnt > DEPTH_N) ? DEPTH_N : bus.exp_cnt;
    assign n_m1    = n - ONE_N;
    assign adr_eq  = (bus.dataadr == tbl_adr[ptr]);
    assign data_eq = (bus.writedata == tbl_data[ptr]);
    assign hit     = data_eq && ((CHECK_ADDR == 0) || adr_eq);
    assign last    = ({1'b0, ptr} == n_m1);

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        cap      = 1'b0;
        adv      = 1'b0;
        case (state)
            S_RUN: begin
                if (bus.memwrite) begin
                    if (!hit) begin
                        state_nx = S_FAIL;
                        cap      = 1'b1;
                    end else if (last) begin
                        state_nx = S_PASS;
                    end else begin
                        adv = 1'b1;
                    end
                end
                // A store verdict on this edge takes precedence over the watchdog.
                if (state_nx == S_RUN && cyc == TO_LAST)
                    state_nx = S_TIMEOUT;
            end
            S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
                if (bus.start) begin
                    ld       = 1'b1;
                    state_nx = (n_in == '0) ? S_PASS : S_RUN;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            n           <= '0;
            cyc         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            tmo_q       <= 1'b0;
            err_idx_q   <= '0;
            got_adr_q   <= '0;
            got_data_q  <= '0;
            write_cnt_q <= '0;
        end else begin
            state  <= state_nx;
            // Flags are decoded from the next state so they are true flops.
            busy_q <= (state_nx == S_RUN);
            done_q <= (state_nx == S_PASS) || (state_nx == S_FAIL) || (state_nx == S_TIMEOUT);
            pass_q <= (state_nx == S_PASS);
            fail_q <= (state_nx == S_FAIL);
            tmo_q  <= (state_nx == S_TIMEOUT);
            if (ld) begin
                ptr         <= '0;
                n           <= n_in;
                cyc         <= '0;
                err_idx_q   <= '0;
                got_adr_q   <= '0;
                got_data_q  <= '0;
                write_cnt_q <= '0;
            end else if (state == S_RUN) begin
                cyc <= cyc + CYW'(1);
                if (adv)
                    ptr <= ptr + IDXW'(1);
                if (bus.memwrite && write_cnt_q != '1)
                    write_cnt_q <= write_cnt_q + CNTW'(1);
                if (cap) begin
                    err_idx_q  <= ptr;
                    got_adr_q  <= bus.dataadr;
                    got_data_q <= bus.writedata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.exp_we) begin
            tbl_adr[bus.exp_idx]  <= bus.exp_adr;
            tbl_data[bus.exp_idx] <= bus.exp_data;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.timeout   = tmo_q;
    assign bus.err_idx   = err_idx_q;
    assign bus.got_adr   = got_adr_q;
    assign bus.got_data  = got_data_q;
    assign bus.write_cnt = write_cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker. Two instances share one stimulus stream:
//   ua: CHECK_ADDR=1, TIMEOUT_CYC=500 (full compare)
//   ub: CHECK_ADDR=0, TIMEOUT_CYC=20  (data-only compare, short watchdog)
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        exp_we, start, memwrite;
    logic [2:0]  exp_idx;
    logic [31:0] exp_adr, exp_data, dataadr, writedata;
    logic [3:0]  exp_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_write_checker_if #(.WIDTH(32), .IDXW(3), .CNTW(16)) ifa ();
    mem_write_checker_if #(.WIDTH(32), .IDXW(3), .CNTW(16)) ifb ();

    assign ifa.exp_we = exp_we;     assign ifb.exp_we = exp_we;
    assign ifa.exp_idx = exp_idx;   assign ifb.exp_idx = exp_idx;
    assign ifa.exp_adr = exp_adr;   assign ifb.exp_adr = exp_adr;
    assign ifa.exp_data = exp_data; assign ifb.exp_data = exp_data;
    assign ifa.exp_cnt = exp_cnt;   assign ifb.exp_cnt = exp_cnt;
    assign ifa.start = start;       assign ifb.start = start;
    assign ifa.memwrite = memwrite; assign ifb.memwrite = memwrite;
    assign ifa.dataadr = dataadr;   assign ifb.dataadr = dataadr;
    assign ifa.writedata = writedata; assign ifb.writedata = writedata;

    mem_write_checker #(.WIDTH(32), .IDXW(3), .TIMEOUT_CYC(500), .CHECK_ADDR(1), .CNTW(16))
        ua (.clk(clk), .reset(reset), .bus(ifa));
    mem_write_checker #(.WIDTH(32), .IDXW(3), .TIMEOUT_CYC(20), .CHECK_ADDR(0), .CNTW(16))
        ub (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct packed {
        logic        pass, fail, tmo;
        logic [2:0]  eidx;
        logic [31:0] gadr, gdat;
        logic [15:0] wcnt;
        logic [2:0]  vb;          // ub verdict {pass,fail,timeout}
    } res_t;

    typedef struct packed {
        logic [3:0]        cnt;
        logic [2:0][31:0]  eadr, edat;
        logic [2:0][31:0]  sadr, sdat;
        logic [1:0]        nst;
        logic [7:0]        gap;
        res_t              exp;
    } vec_t;

    vec_t vecs[$];
    res_t sb[$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, want);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic load(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
        exp_we = 1'b1; exp_idx = idx; exp_adr = a; exp_data = d;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] c);
        exp_cnt = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_busy"}, 32'(ifa.busy), 0);
        chk({tag, "_done"}, 32'(ifa.done), 0);
        chk({tag, "_pass"}, 32'(ifa.pass), 0);
        chk({tag, "_fail"}, 32'(ifa.fail), 0);
        chk({tag, "_tmo"}, 32'(ifa.timeout), 0);
        chk({tag, "_eidx"}, 32'(ifa.err_idx), 0);
        chk({tag, "_gadr"}, ifa.got_adr, 0);
        chk({tag, "_gdat"}, ifa.got_data, 0);
        chk({tag, "_wcnt"}, 32'(ifa.write_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit got=expired exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t v;
        res_t r;
        int   k;
        reset = 1'b1; exp_we = 0; start = 0; memwrite = 0;
        exp_idx = 0; exp_adr = 0; exp_data = 0; exp_cnt = 0; dataadr = 0; writedata = 0;
        repeat (3) tick();
        chk_zero_a("reset");
        reset = 1'b0;

        // v0: single store of 21 at 0x54 on the 20th cycle after start
        v = '0; v.cnt = 1; v.eadr[0] = 32'h54; v.edat[0] = 21; v.sadr[0] = 32'h54; v.sdat[0] = 21;
        v.nst = 1; v.gap = 19; v.exp.pass = 1; v.exp.wcnt = 1; v.exp.vb = 3'b100; vecs.push_back(v);
        // v1: second of three stores has wrong data; third store must be ignored
        v = '0; v.cnt = 3; v.eadr = {32'h58, 32'h54, 32'h50}; v.edat = {32'd3, 32'd21, 32'd7};
        v.sadr = {32'h58, 32'h54, 32'h50}; v.sdat = {32'd3, 32'd22, 32'd7}; v.nst = 3; v.gap = 1;
        v.exp.fail = 1; v.exp.eidx = 1; v.exp.gadr = 32'h54; v.exp.gdat = 22; v.exp.wcnt = 2;
        v.exp.vb = 3'b010; vecs.push_back(v);
        // v2: right data, wrong address: full compare fails, data-only passes
        v = '0; v.cnt = 1; v.eadr[0] = 32'h54; v.edat[0] = 21; v.sadr[0] = 32'h60; v.sdat[0] = 21;
        v.nst = 1; v.gap = 2; v.exp.fail = 1; v.exp.gadr = 32'h60; v.exp.gdat = 21; v.exp.wcnt = 1;
        v.exp.vb = 3'b100; vecs.push_back(v);
        // v3: three matching stores
        v = '0; v.cnt = 3; v.eadr = {32'h58, 32'h54, 32'h50}; v.edat = {32'd3, 32'd21, 32'd7};
        v.sadr = v.eadr; v.sdat = v.edat; v.nst = 3; v.gap = 1;
        v.exp.pass = 1; v.exp.wcnt = 3; v.exp.vb = 3'b100; vecs.push_back(v);
        // v4: n=2 back-to-back; a bad third store arrives after PASS and is not seen
        v = '0; v.cnt = 2; v.eadr = {32'h58, 32'h54, 32'h50}; v.edat = {32'd3, 32'd21, 32'd7};
        v.sadr = {32'h58, 32'h54, 32'h50}; v.sdat = {32'd99, 32'd21, 32'd7}; v.nst = 3; v.gap = 0;
        v.exp.pass = 1; v.exp.wcnt = 2; v.exp.vb = 3'b100; vecs.push_back(v);
        // v5: last entry address mismatch
        v = '0; v.cnt = 3; v.eadr = {32'h58, 32'h54, 32'h50}; v.edat = {32'd3, 32'd21, 32'd7};
        v.sadr = {32'h5c, 32'h54, 32'h50}; v.sdat = v.edat; v.nst = 3; v.gap = 1;
        v.exp.fail = 1; v.exp.eidx = 2; v.exp.gadr = 32'h5c; v.exp.gdat = 3; v.exp.wcnt = 3;
        v.exp.vb = 3'b100; vecs.push_back(v);

        foreach (vecs[i]) begin
            v = vecs[i];
            pulse_reset();
            for (int e = 0; e < 3; e++) load(3'(e), v.eadr[e], v.edat[e]);
            do_start(v.cnt);
            sb.push_back(v.exp);
            for (int s = 0; s < int'(v.nst); s++) begin
                repeat (int'(v.gap)) tick();
                store(v.sadr[s], v.sdat[s]);
            end
            k = 0;
            while (!ifa.done && k < 100) begin tick(); k++; end
            if (!ifa.done) chk($sformatf("v%0d_done_wait", i), 32'(ifa.done), 1);
            r = sb.pop_front();
            chk($sformatf("v%0d_pass", i), 32'(ifa.pass), 32'(r.pass));
            chk($sformatf("v%0d_fail", i), 32'(ifa.fail), 32'(r.fail));
            chk($sformatf("v%0d_tmo", i), 32'(ifa.timeout), 32'(r.tmo));
            chk($sformatf("v%0d_eidx", i), 32'(ifa.err_idx), 32'(r.eidx));
            chk($sformatf("v%0d_gadr", i), ifa.got_adr, r.gadr);
            chk($sformatf("v%0d_gdat", i), ifa.got_data, r.gdat);
            chk($sformatf("v%0d_wcnt", i), 32'(ifa.write_cnt), 32'(r.wcnt));
            chk($sformatf("v%0d_b_verdict", i), 32'({ifb.pass, ifb.fail, ifb.timeout}), 32'(r.vb));
        end

        // One-cycle verdict latency, then restart from PASS
        pulse_reset();
        load(0, 32'h54, 21);
        do_start(1);
        chk("lat_busy", 32'(ifa.busy), 1);
        chk("lat_done0", 32'(ifa.done), 0);
        tick(); tick();
        memwrite = 1'b1; dataadr = 32'h54; writedata = 21;
        chk("lat_pass_before", 32'(ifa.pass), 0);
        tick(); memwrite = 1'b0;
        chk("lat_pass_after", 32'(ifa.pass), 1);
        chk("lat_done_after", 32'(ifa.done), 1);
        chk("lat_busy_after", 32'(ifa.busy), 0);
        do_start(1);
        chk("restart_pass_clr", 32'(ifa.pass), 0);
        chk("restart_busy", 32'(ifa.busy), 1);
        chk("restart_wcnt", 32'(ifa.write_cnt), 0);
        store(32'h54, 21);
        chk("restart_pass", 32'(ifa.pass), 1);

        // exp_cnt = 0 passes immediately
        do_start(0);
        chk("cnt0_pass", 32'(ifa.pass), 1);
        chk("cnt0_busy", 32'(ifa.busy), 0);

        // Watchdog on ub: timeout exactly 20 cycles after start
        do_start(1);
        repeat (19) tick();
        chk("tmo_before", 32'(ifb.timeout), 0);
        chk("tmo_busy_before", 32'(ifb.busy), 1);
        tick();
        chk("tmo_at", 32'(ifb.timeout), 1);
        chk("tmo_pass", 32'(ifb.pass), 0);
        chk("tmo_fail", 32'(ifb.fail), 0);

        // Final matching store on the watchdog's last cycle: pass wins
        pulse_reset();
        do_start(1);
        repeat (19) tick();
        store(32'h54, 21);
        chk("race_pass", 32'(ifb.pass), 1);
        chk("race_tmo", 32'(ifb.timeout), 0);

        // Reset mid-RUN aborts; table survives; rerun reproduces v1
        pulse_reset();
        load(0, 32'h50, 7); load(1, 32'h54, 21); load(2, 32'h58, 3);
        do_start(3);
        store(32'h50, 7);
        tick();
        pulse_reset();
        chk_zero_a("midrst");
        do_start(3);
        store(32'h50, 7);
        store(32'h54, 22);
        chk("retain_fail", 32'(ifa.fail), 1);
        chk("retain_eidx", 32'(ifa.err_idx), 1);
        chk("retain_gadr", ifa.got_adr, 32'h54);
        chk("retain_gdat", ifa.got_data, 22);
        chk("retain_wcnt", 32'(ifa.write_cnt), 2);

        // exp_cnt above DEPTH clamps to 8 entries
        pulse_reset();
        for (int e = 0; e < 8; e++) load(3'(e), 32'(e * 4), 32'(e + 100));
        do_start(4'd15);
        for (int e = 0; e < 7; e++) store(32'(e * 4), 32'(e + 100));
        chk("clamp_busy7", 32'(ifa.busy), 1);
        store(32'd28, 32'd107);
        chk("clamp_pass", 32'(ifa.pass), 1);
        chk("clamp_wcnt", 32'(ifa.write_cnt), 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
